cpu_fetch_seq: RTL and testbench
================================

Name: cpu_fetch_seq

Overview:
Fetch sequencer for the moxie front end. It owns the fetch PC and issues 32-bit instruction-word reads over a single-outstanding request/ack memory port. It writes returned words into the instruction FIFO (cpu_ififo) and handles pipeline stall and branch redirect, including FIFO flush and discard of a stale in-flight read. It replaces the ad-hoc PC/MEM loop that currently drives the FIFO.

Parameters:
BOOT_ADDRESS, 32'h00001000, PC value loaded on reset
ADDR_STEP, 4, byte increment of PC per fetched word

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  reset, asynchronous, active-high
stall_i  input  1  pipeline interlock; blocks issue of new fetches
branch_flag_i  input  1  redirect request, single-cycle pulse
branch_target_i  input  32  redirect byte address, valid with branch_flag_i
ififo_afull_i  input  1  FIFO has at most one free entry
ififo_wren_o  output  1  FIFO write strobe
ififo_data_o  output  32  word to FIFO, first byte in [31:24]
ififo_flush_o  output  1  FIFO clear, single-cycle pulse
mem_req_o  output  1  read request, held until ack
mem_addr_o  output  32  read byte address, stable while mem_req_o=1
mem_ack_i  input  1  read done, single-cycle, mem_data_i valid
mem_data_i  input  32  read data
pc_o  output  32  address of next word to fetch
busy_o  output  1  request outstanding (state != IDLE)

Behaviour:
- All outputs are registered. Asynchronous reset values:
  - mem_req_o=0, mem_addr_o=BOOT_ADDRESS, pc_o=BOOT_ADDRESS.
  - ififo_wren_o=0, ififo_data_o=0, ififo_flush_o=0, busy_o=0.
  - State=IDLE, target latch=0.
- Issue condition: can_issue = !stall_i && !ififo_afull_i && !branch_flag_i.
- State IDLE:
  - If can_issue, then next cycle mem_req_o=1, mem_addr_o=pc_o, go to REQ.
  - If branch_flag_i, then next cycle pc_o=branch_target_i, ififo_flush_o=1, stay IDLE.
- State REQ, mem_ack_i=1 and no branch:
  - Next cycle ififo_wren_o=1, ififo_data_o=mem_data_i, pc_o=pc_o+ADDR_STEP.
  - If can_issue, keep mem_req_o=1 with mem_addr_o=pc_o+ADDR_STEP and stay REQ (back-to-back, one word per ack).
  - Otherwise mem_req_o=0 and go to IDLE.
- State REQ, mem_ack_i=0 and no branch: hold mem_req_o and mem_addr_o.
- State REQ, branch_flag_i=1 with mem_ack_i=0:
  - Latch target, flush pulse next cycle, go to DISCARD.
  - mem_req_o and mem_addr_o are held; a request is never withdrawn before ack.
- State REQ, branch_flag_i=1 with mem_ack_i=1 (same cycle):
  - Data dropped, no FIFO write.
  - pc_o=branch_target_i, flush pulse, mem_req_o=0, go to IDLE.
- State DISCARD:
  - On mem_ack_i: data dropped, pc_o=latched target, mem_req_o=0, go to IDLE.
  - Further branch_flag_i while in DISCARD: re-latch target (latest wins) and pulse flush again.
  - Branch and ack in the same cycle: the new target wins.
- ififo_wren_o and ififo_flush_o are never both 1.
- A word returned for a request issued before a redirect never reaches the FIFO.
- stall_i does not abort an in-flight request. The word is written on ack; the afull issue rule guarantees space.
- PC arithmetic is modulo 2^32 (32'hFFFFFFFC+4 -> 0). branch_target_i is used unmodified (2-byte alignment allowed).
- Minimum latency: issue condition in cycle N gives mem_req_o=1 in N+1. Ack in cycle M gives ififo_wren_o=1 in M+1.
- Reset mid-request: mem_req_o drops immediately (asynchronous); the memory side must tolerate the abandoned request.

Test Plan:
- Release reset, memory ack one cycle after each req, words 0xAABBCCDD, 0x11223344 -> reads at 0x1000 and 0x1004 back-to-back; wren pulses carry those words; pc_o=0x1008.
- Hold stall_i=1 from reset -> mem_req_o stays 0 and pc_o=0x1000. Raise stall_i during an outstanding req -> that word is written, no new req until stall_i=0.
- Branch to 0x2002 in IDLE -> flush pulse next cycle, then req at 0x2002. Branch to 0x3000 during REQ with ack 3 cycles later -> flush pulse, the acked word is not written, next req at 0x3000.
- Branch to 0x4000 and ack in the same cycle -> no write, flush=1, next req at 0x4000. Two branches in DISCARD (0x5000 then 0x6000) -> two flush pulses, next req at 0x6000.
- ififo_afull_i=1 -> no new req after the current ack. Branch target 0xFFFFFFFC -> reads 0xFFFFFFFC then 0x00000000.
- Assert rst_i asynchronously mid-REQ -> mem_req_o=0 before the next clock edge; all outputs at reset values; fetch restarts at 0x1000.

Source files
------------

// File: rtl/cpu_fetch_seq.sv
// cpu_fetch_seq: fetch sequencer for the moxie front end.
// Owns the fetch PC and issues one 32-bit instruction read at a time over a
// request/ack port. Returned words go into the instruction FIFO. Redirects
// flush the FIFO, and a read that was already in flight is discarded.
module cpu_fetch_seq #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h00001000,
  parameter logic [31:0] ADDR_STEP    = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        ififo_afull_i,
  output logic        ififo_wren_o,
  output logic [31:0] ififo_data_o,
  output logic        ififo_flush_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] pc_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t      state_reg,  state_next;
  logic [31:0] pc_reg,     pc_next;
  logic        req_reg,    req_next;
  logic [31:0] addr_reg,   addr_next;
  logic        wren_reg,   wren_next;
  logic [31:0] data_reg,   data_next;
  logic        flush_reg,  flush_next;
  logic [31:0] target_reg, target_next;
  logic        busy_reg,   busy_next;

  logic        can_issue;
  logic [31:0] pc_inc;

  // A new fetch may start only with a free pipeline, FIFO room and no redirect.
  assign can_issue = !stall_i && !ififo_afull_i && !branch_flag_i;
  // Wraps modulo 2^32 naturally.
  assign pc_inc    = pc_reg + ADDR_STEP;

  // State and output registers; reset drops the request immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= ST_IDLE;
      pc_reg     <= BOOT_ADDRESS;
      req_reg    <= 1'b0;
      addr_reg   <= BOOT_ADDRESS;
      wren_reg   <= 1'b0;
      data_reg   <= 32'd0;
      flush_reg  <= 1'b0;
      target_reg <= 32'd0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      req_reg    <= req_next;
      addr_reg   <= addr_next;
      wren_reg   <= wren_next;
      data_reg   <= data_next;
      flush_reg  <= flush_next;
      target_reg <= target_next;
      busy_reg   <= busy_next;
    end
  end

  // Next-state and next-output decode; strobes default low, everything else holds.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    req_next    = req_reg;
    addr_next   = addr_reg;
    wren_next   = 1'b0;
    data_next   = data_reg;
    flush_next  = 1'b0;
    target_next = target_reg;

    case (state_reg)
      ST_IDLE: begin
        if (branch_flag_i) begin
          pc_next    = branch_target_i;
          flush_next = 1'b1;
        end else if (can_issue) begin
          req_next   = 1'b1;
          addr_next  = pc_reg;
          state_next = ST_REQ;
        end
      end

      ST_REQ: begin
        if (branch_flag_i && mem_ack_i) begin
          // The word arriving now is stale: drop it and redirect at once.
          pc_next    = branch_target_i;
          flush_next = 1'b1;
          req_next   = 1'b0;
          state_next = ST_IDLE;
        end else if (branch_flag_i) begin
          // The request cannot be withdrawn, so wait for its ack and drop it.
          target_next = branch_target_i;
          flush_next  = 1'b1;
          state_next  = ST_DISCARD;
        end else if (mem_ack_i) begin
          wren_next = 1'b1;
          data_next = mem_data_i;
          pc_next   = pc_inc;
          if (can_issue) begin
            addr_next = pc_inc;
          end else begin
            req_next   = 1'b0;
            state_next = ST_IDLE;
          end
        end
      end

      ST_DISCARD: begin
        if (branch_flag_i) begin
          // The latest redirect wins, even in the same cycle as the ack.
          target_next = branch_target_i;
          flush_next  = 1'b1;
          if (mem_ack_i) begin
            pc_next    = branch_target_i;
            req_next   = 1'b0;
            state_next = ST_IDLE;
          end
        end else if (mem_ack_i) begin
          pc_next    = target_reg;
          req_next   = 1'b0;
          state_next = ST_IDLE;
        end
      end

      default: begin
        req_next   = 1'b0;
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  assign ififo_wren_o  = wren_reg;
  assign ififo_data_o  = data_reg;
  assign ififo_flush_o = flush_reg;
  assign mem_req_o     = req_reg;
  assign mem_addr_o    = addr_reg;
  assign pc_o          = pc_reg;
  assign busy_o        = busy_reg;

endmodule

// File: tb/tb_cpu_fetch_seq.sv
// tb_cpu_fetch_seq: directed cycle vectors for cpu_fetch_seq, plus a
// hand-written asynchronous reset sequence in the middle of a request.
module tb_cpu_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        afull;
  logic        wren;
  logic [31:0] wdata;
  logic        flush;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] mdata;
  logic [31:0] pc;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic        afull;
    logic        ack;
    logic [31:0] mdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_wren;
    logic [31:0] e_wdata;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_busy;
  } vec_t;

  vec_t vec_q[$];

  cpu_fetch_seq dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_i         (stall),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .ififo_afull_i   (afull),
    .ififo_wren_o    (wren),
    .ififo_data_o    (wdata),
    .ififo_flush_o   (flush),
    .mem_req_o       (req),
    .mem_addr_o      (addr),
    .mem_ack_i       (ack),
    .mem_data_i      (mdata),
    .pc_o            (pc),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h, want %h", name, idx, act, exp);
    end
  endtask

  // Compare every output against one expected set.
  task automatic check_all(input int idx, input logic e_req, input logic [31:0] e_addr,
                           input logic e_wren, input logic [31:0] e_wdata, input logic e_flush,
                           input logic [31:0] e_pc, input logic e_busy);
    check("mem_req",  idx, {31'd0, req},   {31'd0, e_req});
    check("mem_addr", idx, addr,           e_addr);
    check("wren",     idx, {31'd0, wren},  {31'd0, e_wren});
    check("wdata",    idx, wdata,          e_wdata);
    check("flush",    idx, {31'd0, flush}, {31'd0, e_flush});
    check("pc",       idx, pc,             e_pc);
    check("busy",     idx, {31'd0, busy},  {31'd0, e_busy});
    check("wren_and_flush", idx, {31'd0, wren & flush}, 32'd0);
  endtask

  // Inputs for one cycle, then the outputs required after that cycle's edge.
  task automatic add(input logic s, input logic b, input logic [31:0] t, input logic af,
                     input logic a, input logic [31:0] d,
                     input logic er, input logic [31:0] ea, input logic ew,
                     input logic [31:0] ed, input logic ef, input logic [31:0] ep, input logic eb);
    vec_t v;
    v.stall = s;  v.branch = b; v.target = t; v.afull = af; v.ack = a; v.mdata = d;
    v.e_req = er; v.e_addr = ea; v.e_wren = ew; v.e_wdata = ed;
    v.e_flush = ef; v.e_pc = ep; v.e_busy = eb;
    vec_q.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   stall br target        afull ack mdata          req addr          wren wdata          flush pc             busy
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h00001000, 0, 32'h00000000, 0, 32'h00001000, 1); // 0 first issue
    add(0, 0, 32'h0,          0, 1, 32'hAABBCCDD,   1, 32'h00001004, 1, 32'hAABBCCDD, 0, 32'h00001004, 1); // 1 back-to-back
    add(1, 0, 32'h0,          0, 1, 32'h11223344,   0, 32'h00001004, 1, 32'h11223344, 0, 32'h00001008, 0); // 2 stall stops issue
    add(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h00001004, 0, 32'h11223344, 0, 32'h00001008, 0); // 3
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h00001008, 0, 32'h11223344, 0, 32'h00001008, 1); // 4 resume
    add(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h00001008, 0, 32'h11223344, 0, 32'h00001008, 1); // 5 stall in flight
    add(1, 0, 32'h0,          0, 1, 32'hCAFEF00D,   0, 32'h00001008, 1, 32'hCAFEF00D, 0, 32'h0000100C, 0); // 6 word still written
    add(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h00001008, 0, 32'hCAFEF00D, 0, 32'h0000100C, 0); // 7
    add(0, 1, 32'h00002002,   0, 0, 32'h0,          0, 32'h00001008, 0, 32'hCAFEF00D, 1, 32'h00002002, 0); // 8 branch in IDLE
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h00002002, 0, 32'hCAFEF00D, 0, 32'h00002002, 1); // 9
    add(0, 1, 32'h00003000,   0, 0, 32'h0,          1, 32'h00002002, 0, 32'hCAFEF00D, 1, 32'h00002002, 1); // 10 branch in REQ
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h00002002, 0, 32'hCAFEF00D, 0, 32'h00002002, 1); // 11
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h00002002, 0, 32'hCAFEF00D, 0, 32'h00002002, 1); // 12
    add(0, 0, 32'h0,          0, 1, 32'hDEADBEEF,   0, 32'h00002002, 0, 32'hCAFEF00D, 0, 32'h00003000, 0); // 13 stale word dropped
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h00003000, 0, 32'hCAFEF00D, 0, 32'h00003000, 1); // 14
    add(0, 1, 32'h00004000,   0, 1, 32'hBAD0BAD0,   0, 32'h00003000, 0, 32'hCAFEF00D, 1, 32'h00004000, 0); // 15 branch+ack
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h00004000, 0, 32'hCAFEF00D, 0, 32'h00004000, 1); // 16
    add(0, 1, 32'h00005000,   0, 0, 32'h0,          1, 32'h00004000, 0, 32'hCAFEF00D, 1, 32'h00004000, 1); // 17 to DISCARD
    add(0, 1, 32'h00006000,   0, 0, 32'h0,          1, 32'h00004000, 0, 32'hCAFEF00D, 1, 32'h00004000, 1); // 18 re-latch
    add(0, 0, 32'h0,          0, 1, 32'h0BADF00D,   0, 32'h00004000, 0, 32'hCAFEF00D, 0, 32'h00006000, 0); // 19 latest wins
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h00006000, 0, 32'hCAFEF00D, 0, 32'h00006000, 1); // 20
    add(0, 0, 32'h0,          1, 1, 32'h01020304,   0, 32'h00006000, 1, 32'h01020304, 0, 32'h00006004, 0); // 21 afull
    add(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h00006000, 0, 32'h01020304, 0, 32'h00006004, 0); // 22
    add(0, 1, 32'hFFFFFFFC,   0, 0, 32'h0,          0, 32'h00006000, 0, 32'h01020304, 1, 32'hFFFFFFFC, 0); // 23 top of space
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'hFFFFFFFC, 0, 32'h01020304, 0, 32'hFFFFFFFC, 1); // 24
    add(0, 0, 32'h0,          0, 1, 32'h55667788,   1, 32'h00000000, 1, 32'h55667788, 0, 32'h00000000, 1); // 25 wrap
    add(1, 0, 32'h0,          0, 1, 32'h99AABBCC,   0, 32'h00000000, 1, 32'h99AABBCC, 0, 32'h00000004, 0); // 26
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h00000004, 0, 32'h99AABBCC, 0, 32'h00000004, 1); // 27
    add(0, 1, 32'h00007000,   0, 0, 32'h0,          1, 32'h00000004, 0, 32'h99AABBCC, 1, 32'h00000004, 1); // 28 DISCARD
    add(0, 1, 32'h00008000,   0, 1, 32'h77777777,   0, 32'h00000004, 0, 32'h99AABBCC, 1, 32'h00008000, 0); // 29 br+ack in DISCARD
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h00008000, 0, 32'h99AABBCC, 0, 32'h00008000, 1); // 30

    // Reset state.
    rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = '0;
    afull = 1'b0; ack = 1'b0; mdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all(-1, 1'b0, 32'h00001000, 1'b0, 32'h0, 1'b0, 32'h00001000, 1'b0);
    $display("reset: req=%0b addr=%h pc=%h busy=%0b", req, addr, pc, busy);
    rst = 1'b0;

    // Table-driven cycles.
    for (int i = 0; i < vec_q.size(); i++) begin
      stall = vec_q[i].stall; branch_flag = vec_q[i].branch; branch_target = vec_q[i].target;
      afull = vec_q[i].afull; ack = vec_q[i].ack; mdata = vec_q[i].mdata;
      @(posedge clk);
      #1;
      check_all(i, vec_q[i].e_req, vec_q[i].e_addr, vec_q[i].e_wren, vec_q[i].e_wdata,
                vec_q[i].e_flush, vec_q[i].e_pc, vec_q[i].e_busy);
      $display("step %0d: req=%0b addr=%h wren=%0b data=%h flush=%0b pc=%h busy=%0b",
               i, req, addr, wren, wdata, flush, pc, busy);
    end

    // Asynchronous reset while a request is outstanding at 0x8000.
    stall = 1'b0; branch_flag = 1'b0; afull = 1'b0; ack = 1'b0; mdata = '0;
    #3;
    rst = 1'b1;
    #1;
    check_all(100, 1'b0, 32'h00001000, 1'b0, 32'h0, 1'b0, 32'h00001000, 1'b0);
    $display("async reset: req=%0b addr=%h pc=%h busy=%0b", req, addr, pc, busy);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all(101, 1'b1, 32'h00001000, 1'b0, 32'h0, 1'b0, 32'h00001000, 1'b1);
    $display("restart: req=%0b addr=%h pc=%h busy=%0b", req, addr, pc, busy);
    ack = 1'b1; mdata = 32'h13579BDF; stall = 1'b1;
    @(posedge clk);
    #1;
    check_all(102, 1'b0, 32'h00001000, 1'b1, 32'h13579BDF, 1'b0, 32'h00001004, 1'b0);
    $display("restart word: wren=%0b data=%h pc=%h", wren, wdata, pc);
    ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
